// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer/UART-side signal bundle for the tx arbiter
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_done;
  logic [DW-1:0]      dintx;
  logic               newd;
  logic               donetx;
  logic               busy;
  logic [GW-1:0]      grant_id;
  logic               timeout_err;

  // master: producers plus the UART done flag; slave: the arbiter itself
  modport master (
    output req, req_data, donetx,
    input  req_ack, req_done, dintx, newd, busy, grant_id, timeout_err
  );

  modport slave (
    input  req, req_data, donetx,
    output req_ack, req_done, dintx, newd, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ producers
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int NEWD_HOLD   = 104,
  parameter int TIMEOUT_CYC = 2048
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (NEWD_HOLD > TIMEOUT_CYC) ? NEWD_HOLD : TIMEOUT_CYC;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            newd_r, newd_n;
  logic [DW-1:0]   dintx_r, dintx_n;
  logic [GW-1:0]   grant_r, grant_n;
  logic [NREQ-1:0] ack_r, ack_n;
  logic [NREQ-1:0] done_r, done_n;
  logic            terr_r, terr_n;
  logic            donetx_q;
  logic            done_rise;

  logic            found;
  logic [GW-1:0]   win;
  logic [GW-1:0]   cand;
  logic [DW-1:0]   data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = bus.req_data[g*DW +: DW];
  end

  assign done_rise = bus.donetx & ~donetx_q;

  // Rotating search starting just after the last owner
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(grant_r) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    newd_n  = newd_r;
    dintx_n = dintx_r;
    grant_n = grant_r;
    ack_n   = '0;
    done_n  = '0;
    terr_n  = terr_r;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n    = win;
          dintx_n    = data_arr[win];
          ack_n[win] = 1'b1;
          newd_n     = 1'b1;
          cnt_n      = '0;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == CW'(NEWD_HOLD - 1)) begin
          newd_n  = 1'b0;
          cnt_n   = '0;
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        // A completion on the last allowed cycle still counts as success
        if (done_rise) begin
          done_n[grant_r] = 1'b1;
          state_n         = RELEASE;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          terr_n  = 1'b1;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      newd_r   <= 1'b0;
      dintx_r  <= '0;
      grant_r  <= GW'(NREQ - 1);
      ack_r    <= '0;
      done_r   <= '0;
      terr_r   <= 1'b0;
      donetx_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      newd_r   <= newd_n;
      dintx_r  <= dintx_n;
      grant_r  <= grant_n;
      ack_r    <= ack_n;
      done_r   <= done_n;
      terr_r   <= terr_n;
      donetx_q <= bus.donetx;
    end
  end

  assign bus.req_ack     = ack_r;
  assign bus.req_done    = done_r;
  assign bus.dintx       = dintx_r;
  assign bus.newd        = newd_r;
  assign bus.busy        = (state != IDLE);
  assign bus.grant_id    = grant_r;
  assign bus.timeout_err = terr_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - frame-level checks of uart_tx_arbiter: vector table, corner sequences, random frames
module tb_uart_tx_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   model_last;
  bit   model_terr;

  uart_tx_arbiter_if #(.NREQ(4), .DW(8)) bus();

  uart_tx_arbiter #(
    .NREQ(4), .DW(8), .NEWD_HOLD(104), .TIMEOUT_CYC(2048)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          dly;
    int          dlen;
    bit          stale;
    int          g;
    logic [7:0]  b;
    bit          terr;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (((m >> ((last + k) % 4)) & 4'd1) != 4'd0) return (last + k) % 4;
    end
    return -1;
  endfunction

  // One complete frame; dly < 0 means the UART never answers
  task automatic do_frame(input string tag, input logic [3:0] mask, input logic [31:0] data,
                          input int dly, input int dlen, input bit stale,
                          input int exp_g, input logic [7:0] exp_b, input bit exp_terr);
    int         lat, nlen, pulses, busy_late, k;
    bit         bad_dintx, early_done, ack_long;
    logic [3:0] ack, exp_mask, rest;
    exp_mask = 4'b0001 << exp_g;
    bus.req = mask;
    bus.req_data = data;
    lat = 0;
    ack = '0;
    for (int w = 1; w <= 8; w++) begin
      @(negedge clk);
      if (bus.req_ack != 4'b0) begin
        lat = w;
        ack = bus.req_ack;
        break;
      end
    end
    check({tag, " ack_latency"}, lat, 1);
    check({tag, " req_ack"}, ack, exp_mask);
    if (lat == 0) begin
      bus.req = '0;
      return;
    end
    check({tag, " grant_id"}, bus.grant_id, exp_g);
    rest = mask & ~ack;
    bus.req = rest;
    nlen = 0;
    bad_dintx = 0;
    early_done = 0;
    ack_long = 0;
    while (bus.newd && nlen < 300) begin
      nlen++;
      if (bus.dintx !== exp_b) bad_dintx = 1;
      if (bus.req_done != 4'b0) early_done = 1;
      if (nlen == 2 && bus.req_ack != 4'b0) ack_long = 1;
      bus.donetx = stale && (nlen >= 10) && (nlen < 13);
      @(negedge clk);
    end
    bus.donetx = 1'b0;
    check({tag, " newd_len"}, nlen, 104);
    check({tag, " dintx_hold"}, bad_dintx, 0);
    check({tag, " done_in_issue"}, early_done, 0);
    check({tag, " ack_width"}, ack_long, 0);
    pulses = 0;
    busy_late = 0;
    if (dly >= 0) begin
      repeat (dly) begin
        @(negedge clk);
        if (bus.req_done != 4'b0) pulses++;
      end
      bus.donetx = 1'b1;
      for (int j = 1; j <= dlen + 2; j++) begin
        @(negedge clk);
        if (j >= dlen || (j >= 2 && rest != 4'b0)) bus.donetx = 1'b0;
        if (j == 1) begin
          check({tag, " req_done"}, bus.req_done, exp_mask);
          check({tag, " busy_release"}, bus.busy, 1);
        end else if (bus.req_done != 4'b0) begin
          pulses++;
        end
        if (j == 2) check({tag, " busy_fall"}, bus.busy, 0);
        if (j >= 3 && bus.busy) busy_late++;
        if (j == 2 && rest != 4'b0) break;
      end
      bus.donetx = 1'b0;
      check({tag, " busy_after_level"}, busy_late, 0);
    end else begin
      k = 0;
      while (!bus.timeout_err && k < 3000) begin
        if (bus.req_done != 4'b0) pulses++;
        @(negedge clk);
        k++;
      end
      check({tag, " timeout_cycles"}, k, 2048);
      @(negedge clk);
      check({tag, " busy_after_timeout"}, bus.busy, 0);
    end
    check({tag, " extra_done"}, pulses, 0);
    check({tag, " timeout_err"}, bus.timeout_err, exp_terr);
  endtask

  initial begin
    logic [3:0]  m;
    logic [31:0] d;
    int          w;
    n_tests = 0;
    n_fail = 0;
    tbl[0]  = '{4'b1111, 32'h44332211, 2, 1,  0, 0, 8'h11, 0};
    tbl[1]  = '{4'b1111, 32'h44332211, 3, 1,  0, 1, 8'h22, 0};
    tbl[2]  = '{4'b1111, 32'h44332211, 1, 2,  1, 2, 8'h33, 0};
    tbl[3]  = '{4'b1111, 32'h44332211, 0, 1,  0, 3, 8'h44, 0};
    tbl[4]  = '{4'b0001, 32'h000000C3, 5, 50, 0, 0, 8'hC3, 0};
    tbl[5]  = '{4'b0100, 32'h00A50000, 0, 1,  0, 2, 8'hA5, 0};
    tbl[6]  = '{4'b0100, 32'h00A60000, 7, 2,  1, 2, 8'hA6, 0};
    tbl[7]  = '{4'b1001, 32'h90000007, 2, 1,  0, 3, 8'h90, 0};
    tbl[8]  = '{4'b1001, 32'h90000007, 2, 1,  0, 0, 8'h07, 0};
    tbl[9]  = '{4'b1000, 32'h90000007, 2, 1,  0, 3, 8'h90, 0};
    tbl[10] = '{4'b0001, 32'h00000055, -1, 1, 0, 0, 8'h55, 1};
    tbl[11] = '{4'b0011, 32'h00005A3C, 4, 1,  0, 1, 8'h5A, 1};
    tbl[12] = '{4'b0011, 32'h00005A3C, 4, 1,  0, 0, 8'h3C, 1};

    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;
    bus.donetx = 1'b0;
    repeat (3) @(negedge clk);
    check("rst req_ack", bus.req_ack, 0);
    check("rst req_done", bus.req_done, 0);
    check("rst dintx", bus.dintx, 0);
    check("rst newd", bus.newd, 0);
    check("rst busy", bus.busy, 0);
    check("rst grant_id", bus.grant_id, 3);
    check("rst timeout_err", bus.timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_frame($sformatf("vec%0d", i), tbl[i].mask, tbl[i].data, tbl[i].dly, tbl[i].dlen,
               tbl[i].stale, tbl[i].g, tbl[i].b, tbl[i].terr);
    end

    // Reset in the middle of newd
    bus.req = 4'b0100;
    bus.req_data = 32'h00770000;
    @(negedge clk);
    check("midrst ack", bus.req_ack, 4'b0100);
    bus.req = '0;
    repeat (49) @(negedge clk);
    check("midrst newd_before", bus.newd, 1);
    rst = 1'b1;
    #1;
    check("midrst newd", bus.newd, 0);
    check("midrst busy", bus.busy, 0);
    check("midrst grant_id", bus.grant_id, 3);
    check("midrst timeout_err", bus.timeout_err, 0);
    check("midrst req_done", bus.req_done, 0);
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.req_done != 4'b0 || bus.busy) w++;
    end
    check("midrst quiet", w, 0);
    do_frame("post_rst", 4'b0010, 32'h0000BE00, 3, 1, 0, 1, 8'hBE, 0);
    model_last = 1;
    model_terr = 0;

    for (int n = 0; n < 30; n++) begin
      m = 4'($urandom_range(1, 15));
      d = $urandom;
      w = rr_pick(model_last, m);
      do_frame($sformatf("rand%0d", n), m, d, int'($urandom_range(0, 20)),
               int'($urandom_range(1, 2)), bit'($urandom_range(0, 1)),
               w, 8'(d >> (8 * w)), model_terr);
      model_last = w;
    end

    bus.req = '0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
